// File: rtl/instr_fetch_queue.sv
// Fetch stage: one outstanding imem request, DEPTH-entry instruction queue, redirect flush.
// Optional FETCH_STATS_EN adds saturating stat_fetched / stat_flushed counters.
module instr_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               advance,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_STATS_EN
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_flushed,
`endif
  output logic [1:0]         fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DISCARD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem [DEPTH];
  logic               credit, do_enq, do_deq, drop;

  // Handshakes: imem_req is a one-cycle issue pulse, imem_valid answers the single
  // outstanding request; instr_valid/advance is valid/ready, head pops when both are high.
  assign credit    = count_q < CW'(DEPTH);
  assign imem_addr = fetch_pc_q;
  assign fsm_state = state_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    do_enq     = 1'b0;
    drop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (credit && !rst) begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (imem_valid) begin
            drop    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DISCARD;
          end
        end else if (imem_valid) begin
          do_enq     = 1'b1;
          fetch_pc_d = fetch_pc_q + 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_DISCARD: begin
        // The stale response is swallowed even if another redirect lands on it.
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_valid) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign do_deq = (count_q != '0) && advance && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (do_enq) tail_q <= tail_q + 1'b1;
        if (do_deq) head_q <= head_q + 1'b1;
        count_q <= count_q + CW'(do_enq) - CW'(do_deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq && !rst) begin
      instr_mem[tail_q] <= imem_data;
      pc_mem[tail_q]    <= fetch_pc_q;
    end
  end

  assign instr_valid = count_q != '0;
  assign instruction = instr_valid ? instr_mem[head_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[head_q] : '0;

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched_q, stat_flushed_q;
  logic [16:0] flushed_sum;

  // Flushed counts queued entries lost to a redirect plus dropped responses.
  assign flushed_sum = {1'b0, stat_flushed_q} + 17'(redirect ? count_q : '0) + 17'(drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (do_enq && stat_fetched_q != 16'hFFFF) stat_fetched_q <= stat_fetched_q + 1'b1;
      stat_flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_flushed = stat_flushed_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, checked by a
// transaction-level model (expected queue, next fetch PC, pending-request flags).
module tb_instr_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 19;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    instr_pc;
  logic               advance;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [1:0]         fsm_state;
`ifdef FETCH_STATS_EN
  logic [15:0]        stat_fetched;
  logic [15:0]        stat_flushed;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .advance(advance), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched), .stat_flushed(stat_flushed),
`endif
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver + memory model ----------------
  logic            rst_drive = 1'b1;
  logic            mem_busy  = 1'b0;
  int              mem_wait  = 0;
  logic [PC_W-1:0] mem_addr  = '0;
  int              latency   = 1;
  logic            rand_data = 1'b0;
  int              req_cnt   = 0;
  logic [PC_W-1:0] req_log[$];

  task automatic cycle(input logic adv, input logic redir, input logic [PC_W-1:0] rpc);
    @(negedge clk);
    rst         = rst_drive;
    advance     = adv;
    redirect    = redir;
    redirect_pc = rpc;
    imem_valid  = 1'b0;
    imem_data   = '0;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_valid = 1'b1;
        imem_data  = rand_data ? 19'($urandom) : (19'h40000 | 19'(mem_addr));
        mem_busy   = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    #2;
    if (imem_req) begin
      req_log.push_back(imem_addr);
      req_cnt++;
      mem_busy = 1'b1;
      mem_wait = latency - 1;
      mem_addr = imem_addr;
    end
  endtask

  task automatic do_reset(input int n);
    rst_drive = 1'b1;
    mem_busy  = 1'b0;
    repeat (n) cycle(1'b0, 1'b0, '0);
    rst_drive = 1'b0;
    req_log.delete();
    req_cnt = 0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [INSTR_W+PC_W-1:0] exp_q[$];
  logic [PC_W-1:0]         m_pc = '0;
  logic                    m_pending = 1'b0;
  logic                    m_stale = 1'b0;
  int                      m_fetched = 0;
  int                      m_flushed = 0;

  initial begin
    logic                    exp_req;
    logic                    do_pop;
    logic [INSTR_W+PC_W-1:0] head_e;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        exp_q.delete();
        m_pc = '0; m_pending = 1'b0; m_stale = 1'b0;
        m_fetched = 0; m_flushed = 0;
      end else begin
        if (exp_q.size() > 0) begin
          head_e = exp_q[0];
          chk("instr_valid", 32'(instr_valid), 32'd1);
          chk("instruction", 32'(instruction), 32'(head_e[PC_W +: INSTR_W]));
          chk("instr_pc", 32'(instr_pc), 32'(head_e[PC_W-1:0]));
        end else begin
          chk("instr_valid_empty", 32'(instr_valid), 32'd0);
          chk("instruction_empty", 32'(instruction), 32'd0);
          chk("instr_pc_empty", 32'(instr_pc), 32'd0);
        end
`ifdef FETCH_STATS_EN
        chk("stat_fetched", 32'(stat_fetched), (m_fetched > 65535) ? 32'hFFFF : 32'(m_fetched));
        chk("stat_flushed", 32'(stat_flushed), (m_flushed > 65535) ? 32'hFFFF : 32'(m_flushed));
`endif
        exp_req = !m_pending && !redirect && (exp_q.size() < DEPTH);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req && exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        do_pop = advance && !redirect && (exp_q.size() > 0);
        if (do_pop) void'(exp_q.pop_front());
        if (imem_valid && m_pending) begin
          if (m_stale || redirect) begin
            m_flushed++;
          end else begin
            exp_q.push_back({imem_data, m_pc});
            m_pc = m_pc + 1'b1;
            m_fetched++;
          end
          m_pending = 1'b0;
          m_stale   = 1'b0;
        end
        if (redirect) begin
          m_flushed += exp_q.size();
          exp_q.delete();
          m_pc = redirect_pc;
          if (m_pending) m_stale = 1'b1;
        end
        if (imem_req && exp_req) m_pending = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [PC_W-1:0] wrap_exp [4];
    rst = 1'b1; advance = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_data = '0;

    // Reset then stream with a 1-cycle memory
    latency = 1;
    do_reset(3);
    repeat (20) cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++)
      chk("stream_addr", (req_log.size() > i) ? 32'(req_log[i]) : 32'hDEAD, 32'(i));

    // Backpressure: queue fills, then a single pop frees one credit
    do_reset(2);
    repeat (15) cycle(1'b0, 1'b0, '0);
    chk("bp_req_count", 32'(req_cnt), 32'd4);
    req_log.delete(); req_cnt = 0;
    cycle(1'b1, 1'b0, '0);
    repeat (8) cycle(1'b0, 1'b0, '0);
    chk("bp_refill_count", 32'(req_cnt), 32'd1);
    chk("bp_refill_addr", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hDEAD, 32'd4);

    // Redirect while a request to 0x005 is outstanding
    do_reset(2);
    latency = 3;
    cycle(1'b0, 1'b1, 12'h005);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 12'h0A0);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end while (!instr_valid && n < 20);
    chk("redir_valid", 32'(instr_valid), 32'd1);
    chk("redir_first_pc", 32'(instr_pc), 32'h0A0);
    chk("redir_first_instr", 32'(instruction), 32'h400A0);

    // Redirect + advance coincident with a response, two entries queued
    do_reset(2);
    latency = 1;
    repeat (5) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 12'h123);
    cycle(1'b0, 1'b0, '0);
    chk("coinc_req", 32'(imem_req), 32'd1);
    chk("coinc_addr", 32'(imem_addr), 32'h123);
    chk("coinc_empty", 32'(instr_valid), 32'd0);

    // PC wrap
    do_reset(2);
    cycle(1'b1, 1'b1, 12'hFFE);
    repeat (12) cycle(1'b1, 1'b0, '0);
    wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 4; i++)
      chk("wrap_addr", (req_log.size() > i) ? 32'(req_log[i]) : 32'hDEAD, 32'(wrap_exp[i]));

    // Reset in WAIT with the response landing right after reset
    do_reset(2);
    latency = 4;
    cycle(1'b0, 1'b1, 12'h033);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    rst_drive = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, '0);
    rst_drive = 1'b0;
    cycle(1'b0, 1'b0, '0);
    chk("late_valid_seen", 32'(imem_valid), 32'd1);
    chk("post_reset_req", 32'(imem_req), 32'd1);
    chk("post_reset_addr", 32'(imem_addr), 32'd0);
    chk("post_reset_empty", 32'(instr_valid), 32'd0);
`ifdef FETCH_STATS_EN
    chk("post_reset_stat", 32'(stat_fetched), 32'd0);
`endif
    repeat (10) cycle(1'b1, 1'b0, '0);

    // Random traffic
    do_reset(2);
    rand_data = 1'b1;
    for (int i = 0; i < 800; i++) begin
      latency = $urandom_range(1, 4);
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5, 12'($urandom));
    end
    repeat (20) cycle(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
